// File: rtl/fft_reorder_pkg.sv
// Shared system definitions: sample/bus types, read FSM states and the bit-reversal helper.
package fft_reorder_pkg;

    localparam int unsigned SAMPLE_WIDTH = 32;

    typedef struct packed {
        logic signed [15:0] data_r;
        logic signed [15:0] data_i;
    } DATA_SAMPLE;

    typedef struct packed {
        logic       valid;
        DATA_SAMPLE data;
    } DATA_BUS;

    typedef enum logic {
        IDLE,
        DRAIN
    } rd_state_t;

    // Reverses the low 'width' bits of value; higher bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < width; i++) begin
            r[i] = value[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ram.sv
// Simple dual-port RAM: synchronous write, synchronous read with one cycle latency.
module ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 1024
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(MEM_SIZE)-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic                        re,
    input  logic [$clog2(MEM_SIZE)-1:0] raddr,
    output logic [DATA_WIDTH-1:0]       rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong bit-reversed to natural-order reorder buffer for the FFT output stream.
// Optional FFT_REORDER_SOF_EN adds a registered sof flag marking natural index 0.
module fft_reorder
    import fft_reorder_pkg::*;
#(
    parameter int unsigned POINT = 512
) (
    input  logic    clk,
    input  logic    rst_n,
    input  DATA_BUS in,
    output DATA_BUS out,
    output logic    busy
`ifdef FFT_REORDER_SOF_EN
    ,
    output logic    sof
`endif
);

    localparam int unsigned     AW   = $clog2(POINT);
    localparam logic [AW-1:0]   LAST = AW'(POINT - 1);

    logic [AW-1:0]           wcnt;
    logic                    wb;
    logic [1:0]              full;
    logic [1:0]              full_next;
    rd_state_t               state;
    logic [AW-1:0]           rcnt;
    logic                    rb;
    logic                    rd_valid;
    logic                    rd_first;
    logic                    frame_done;
    logic                    drain_end;
    logic [AW-1:0]           wrev;
    logic [SAMPLE_WIDTH-1:0] rdata;

    assign frame_done = in.valid && (wcnt == LAST);
    assign drain_end  = (state == DRAIN) && (rcnt == LAST);
    assign wrev       = AW'(bitrev(32'(wcnt), AW));

    ram #(
        .DATA_WIDTH (SAMPLE_WIDTH),
        .MEM_SIZE   (2 * POINT)
    ) u_ram (
        .clk   (clk),
        .we    (in.valid),
        .waddr ({wb, wrev}),
        .wdata (in.data),
        .re    (state == DRAIN),
        .raddr ({rb, rcnt}),
        .rdata (rdata)
    );

    // A bank being drained is released and a freshly completed bank claimed on the same edge.
    always_comb begin
        full_next = full;
        if (drain_end) begin
            full_next[rb] = 1'b0;
        end
        if (frame_done) begin
            full_next[wb] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt     <= '0;
            wb       <= 1'b0;
            full     <= '0;
            state    <= IDLE;
            rcnt     <= '0;
            rb       <= 1'b0;
            rd_valid <= 1'b0;
            rd_first <= 1'b0;
            out      <= '0;
        end else begin
            full <= full_next;
            if (in.valid) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == LAST) begin
                    wb <= ~wb;
                end
            end

            case (state)
                IDLE: begin
                    rcnt <= '0;
                    if (frame_done) begin
                        state <= DRAIN;
                        rb    <= wb;
                    end else if (full != 2'b00) begin
                        state <= DRAIN;
                        rb    <= ~full[0];
                    end
                end
                DRAIN: begin
                    rcnt <= rcnt + 1'b1;
                    if (rcnt == LAST) begin
                        // Continue straight into the other bank for gapless output.
                        if (frame_done || full[~rb]) begin
                            rb <= ~rb;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            rd_valid <= (state == DRAIN);
            rd_first <= (state == DRAIN) && (rcnt == '0);

            if (rd_valid) begin
                out.valid <= 1'b1;
                out.data  <= DATA_SAMPLE'(rdata);
            end else begin
                out <= '0;
            end
        end
    end

`ifdef FFT_REORDER_SOF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sof <= 1'b0;
        end else begin
            sof <= rd_first;
        end
    end
`endif

    assign busy = (wcnt != '0) || (full != 2'b00) || (state == DRAIN) || rd_valid || out.valid;

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder (POINT=8) against a frame-level reorder model.
// Define FFT_REORDER_SOF_EN on both bench and RTL to also check sof.
module tb_fft_reorder;
    import fft_reorder_pkg::*;

    localparam int unsigned POINT = 8;
    localparam int unsigned BITS  = 3;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    DATA_BUS in_bus;
    DATA_BUS out_bus;
    logic    busy;
`ifdef FFT_REORDER_SOF_EN
    logic    sof;
`endif

    fft_reorder #(.POINT(POINT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in_bus),
        .out   (out_bus),
        .busy  (busy)
`ifdef FFT_REORDER_SOF_EN
        ,
        .sof   (sof)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int failures = 0;

    // Model state: pending expected outputs keyed by the cycle they must appear in.
    DATA_SAMPLE exp_data [int];
    bit         exp_sof  [int];
    DATA_SAMPLE frame_buf [POINT];
    int         wpos = 0;
    bit         mon_en = 1'b0;
    int         seq [POINT] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int rev(input int k);
        int r = 0;
        for (int b = 0; b < BITS; b++) begin
            if ((k >> b) & 1) r = r | (1 << (BITS - 1 - b));
        end
        return r;
    endfunction

    function automatic DATA_SAMPLE mk(input int r, input int i);
        DATA_SAMPLE s;
        s.data_r = 16'(r);
        s.data_i = 16'(i);
        return s;
    endfunction

    // Drive one cycle; a valid sample is sampled on the next edge (cycle cyc+1).
    // A complete frame appears in natural order starting two cycles after that edge.
    task automatic push(input logic v, input DATA_SAMPLE d);
        in_bus.valid = v;
        in_bus.data  = d;
        if (v) begin
            frame_buf[rev(wpos)] = d;
            wpos++;
            if (wpos == POINT) begin
                for (int j = 0; j < POINT; j++) exp_data[cyc + 3 + j] = frame_buf[j];
                exp_sof[cyc + 3] = 1'b1;
                wpos = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, mk($urandom, $urandom));
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_data.exists(cyc)) begin
                check("out_valid", 64'(out_bus.valid), 64'(1));
                check("out_data", 64'(out_bus.data), 64'(exp_data[cyc]));
                exp_data.delete(cyc);
            end else begin
                check("out_idle", 64'(out_bus), 64'(0));
            end
`ifdef FFT_REORDER_SOF_EN
            check("sof", 64'(sof), 64'(exp_sof.exists(cyc)));
`endif
            if (exp_sof.exists(cyc)) exp_sof.delete(cyc);
        end
    end

    initial begin
        in_bus = '0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", 64'(out_bus), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single contiguous frame in bit-reversed order.
        for (int k = 0; k < POINT; k++) begin
            push(1'b1, mk(seq[k], $urandom));
            if (k == 0) check("busy_mid_frame", 64'(busy), 64'(1));
        end
        idle(12);
        check("busy_after_frame", 64'(busy), 64'(0));

        // Three back-to-back frames of random data.
        for (int k = 0; k < 3 * POINT; k++) push(1'b1, mk($urandom, $urandom));
        idle(14);
        check("busy_after_b2b", 64'(busy), 64'(0));

        // Same frame with random gaps between samples.
        for (int k = 0; k < POINT; k++) begin
            idle($urandom_range(5));
            push(1'b1, mk(seq[k], $urandom));
        end
        idle(12);

        // Reset mid-frame discards the partial frame.
        for (int k = 0; k < 5; k++) push(1'b1, mk($urandom, $urandom));
        check("busy_before_reset", 64'(busy), 64'(1));
        rst_n = 1'b0;
        push(1'b0, mk($urandom, $urandom));
        rst_n = 1'b1;
        wpos = 0;
        check("busy_after_reset", 64'(busy), 64'(0));
        check("out_after_reset", 64'(out_bus), 64'(0));
        for (int k = 0; k < POINT; k++) push(1'b1, mk(seq[k] + 100, $urandom));
        idle(12);

        // Two more frames with a short gap between them.
        for (int k = 0; k < POINT; k++) push(1'b1, mk($urandom, $urandom));
        idle(3);
        for (int k = 0; k < POINT; k++) push(1'b1, mk($urandom, $urandom));

        for (int i = 0; i < 50 && exp_data.size() != 0; i++) idle(1);
        idle(2);
        check("all_drained", 64'(exp_data.size()), 64'(0));
        check("busy_final", 64'(busy), 64'(0));
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
